// File: rtl/conv_pkg.sv
// Shared constants for the conv frame sequencer: state encoding and default frame geometry.
package conv_pkg;

  localparam int unsigned DEF_WIDTH  = 256;
  localparam int unsigned DEF_HEIGHT = 256;
  localparam int unsigned DEF_BITW   = 8;
  localparam int unsigned FRAME_PIX  = DEF_WIDTH * DEF_HEIGHT;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/conv_slot_pipe.sv
// Fixed-depth valid token delay line; a token entering now leaves DEPTH cycles later.
module conv_slot_pipe
  import conv_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_valid = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: streams one image frame through the 3x3 conv engine and
// writes one result slot per input pixel into the output RAM.
//   state  | meaning
//   IDLE   | waiting for start; read/write counters held at zero
//   STREAM | issuing image RAM reads, one per cycle without hold
//   DRAIN  | all reads issued; waiting for the remaining output slots
//   DONE   | one-cycle done pulse, then back to IDLE
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned HEIGHT   = DEF_HEIGHT,
  parameter int unsigned BITW     = DEF_BITW,
  parameter int          PIPE_LAT = 1,
  parameter int unsigned ADDRW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr,
  input  logic [BITW-1:0]  rd_data,
  output logic             conv_in_valid,
  output logic [BITW-1:0]  conv_in_pix,
  input  logic             conv_out_valid,
  input  logic [7:0]       conv_out_pix,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr,
  output logic [7:0]       wr_data
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(WIDTH * HEIGHT - 1);

  logic [1:0]       state_q, state_d;
  logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRW-1:0] wr_cnt_q, wr_cnt_d;
  logic             civ_q, civ_d;
  logic             err_q, err_d;
  logic             slot;
  logic             start_ok;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = err_q;
    rd_en     = (state_q == STREAM) && !hold;
    start_ok  = (state_q == IDLE) && start;
    civ_d     = rd_en;

    if (rd_en) rd_addr_d = rd_addr_q + 1'b1;
    if (slot)  wr_cnt_d  = wr_cnt_q + 1'b1;

    // A fresh start wins over a stray engine output in the same cycle.
    if (start_ok) begin
      err_d = 1'b0;
    end else if (conv_out_valid && !slot) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        rd_addr_d = '0;
        wr_cnt_d  = '0;
        if (start) state_d = STREAM;
      end
      STREAM: begin
        if (rd_en && (rd_addr_q == LAST_ADDR)) state_d = DRAIN;
      end
      DRAIN: begin
        if (slot && (wr_cnt_q == LAST_ADDR)) state_d = DONE;
      end
      DONE: begin
        wr_cnt_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_cnt_q  <= '0;
      civ_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_cnt_q  <= wr_cnt_d;
      civ_q     <= civ_d;
      err_q     <= err_d;
    end
  end

  conv_slot_pipe #(
    .DEPTH(PIPE_LAT)
  ) u_slot_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (civ_q),
    .out_valid(slot)
  );

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign rd_addr       = rd_addr_q;
  assign conv_in_valid = civ_q;
  assign conv_in_pix   = rd_data;
  assign wr_en         = slot;
  assign wr_addr       = wr_cnt_q;
  assign wr_data       = conv_out_valid ? conv_out_pix : 8'h00;

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer for the streaming 3x3 convolution engine (Top_conv).
- On a start pulse it reads one WIDTH x HEIGHT frame from a 1-cycle-latency image RAM and streams it raster-order into the engine, one pixel per clock unless held.
- It captures one output slot per input pixel, zero-filling border/warm-up slots, and writes a full WIDTH*HEIGHT result frame to an output RAM.
- It signals done and flags misaligned engine output.

Parameters:
- WIDTH, 256, pixels per line.
- HEIGHT, 256, lines per frame.
- BITW, 8, pixel width.
- PIPE_LAT, 1, cycles from the clock edge that samples conv_in_valid to the cycle its output slot is presented; range 1..8.
- ADDRW, 16, address width; must satisfy 2^ADDRW >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start request.
- hold  in  1  pause issuing new pixels.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse, frame fully written.
- err  out  1  sticky: conv_out_valid seen with no slot pending.
- rd_en  out  1  image RAM read strobe.
- rd_addr  out  ADDRW  image RAM address, raster index r*WIDTH+c.
- rd_data  in  BITW  image RAM data, valid the cycle after rd_en.
- conv_in_valid  out  1  to engine in_valid.
- conv_in_pix  out  BITW  to engine in_pix (= rd_data).
- conv_out_valid  in  1  engine out_valid.
- conv_out_pix  in  8  engine out_pix.
- wr_en  out  1  output RAM write strobe.
- wr_addr  out  ADDRW  output RAM address.
- wr_data  out  8  output RAM data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst). While rst=1, all registers clear: state=IDLE, busy=0, done=0, err=0, rd_en=0, rd_addr=0, conv_in_valid=0, token pipe=0, wr_addr=0. rst mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: start=1 -> STREAM.
  - STREAM: issues reads -> DRAIN after address WIDTH*HEIGHT-1 is issued.
  - DRAIN: no reads; -> DONE when write count reaches WIDTH*HEIGHT.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in STREAM, DRAIN and DONE. start is ignored unless in IDLE.
- STREAM read side:
  - rd_en = ~hold (combinational from state and hold).
  - rd_addr increments on each rd_en cycle, starting at 0.
  - hold=1 gives rd_en=0 and freezes rd_addr; hold in DRAIN has no effect.
- Input side:
  - conv_in_valid is rd_en registered one cycle.
  - conv_in_pix = rd_data, combinational.
  - Holds appear at the engine as valid gaps.
- Slot tracking:
  - A token shift register of PIPE_LAT stages is fed by conv_in_valid.
  - slot = last stage output; one slot per pixel delivered to the engine.
- Write side, combinational:
  - wr_en = slot.
  - wr_data = conv_out_valid ? conv_out_pix : 0.
  - wr_addr = write counter, which increments after each wr_en and clears in IDLE.
- err is set when conv_out_valid=1 and slot=0. err clears only on rst or on start accepted in IDLE.
- Timing, no hold, start sampled at edge 0:
  - rd_en/addr 0 in cycle 1.
  - conv_in_valid in cycle 2.
  - First wr_en in cycle 2+PIPE_LAT.
  - Last wr_en (addr N-1, N=WIDTH*HEIGHT) in cycle N+1+PIPE_LAT.
  - done in cycle N+2+PIPE_LAT.
- Simultaneous events: start arriving in the same cycle as done is ignored, because the state is still DONE.

Decomposition:
- Shared package conv_pkg holds:
  - the state encoding localparams (IDLE, STREAM, DRAIN, DONE);
  - the default WIDTH/HEIGHT/BITW;
  - a FRAME_PIX = WIDTH*HEIGHT constant.
- One natural sub-module, conv_slot_pipe: a parameterised PIPE_LAT-deep valid shift register with async reset, reused wherever valid tokens are delayed.

Test Plan:
- 4x4 frame, PIPE_LAT=1, engine model returns out_valid on interior slots with value = input pixel -> exactly 16 writes to addrs 0..15; border addrs get 0; interior addrs get pixel values; done in cycle 19.
- hold=1 for 3 cycles after pixel 5 -> rd_addr frozen at 6; conv_in_valid shows a 3-cycle gap; the write sequence is unchanged; done is delayed by exactly 3 cycles.
- start pulsed again during STREAM and in the DONE cycle -> ignored; only one frame of 16 writes.
- rst asserted asynchronously mid-STREAM (pixel 9) -> all outputs 0 immediately with no done; a new start then produces a clean 16-write frame from addr 0.
- Engine model raises conv_out_valid one cycle after the frame end (no slot) -> err=1 and sticky; the next accepted start clears it.
- PIPE_LAT=3, 256x256 frame -> 65536 writes; done in cycle 65541; wr_addr wraps to 0 in IDLE.
